// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/adder_subtractor.sv
// Shared WIDTH-bit adder/subtractor; subtraction computed as A + ~B + 1.
module adder_subtractor
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             sub;

    always_comb begin
        sub      = (mode == MODE_SUB);
        b_eff    = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one adder_subtractor between N_REQ requesters,
// one operation in flight: IDLE (grant) -> CALC (compute) -> RESP (handshake).
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_mode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_overflow
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] dp_result;
    logic             dp_carry, dp_ovf;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    adder_subtractor #(
        .WIDTH (WIDTH)
    ) u_dp (
        .a        (a_q),
        .b        (b_q),
        .mode     (mode_q),
        .result   (dp_result),
        .carry    (dp_carry),
        .overflow (dp_ovf)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        id_d      = id_q;
        res_d     = res_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        rsp_id_d  = rsp_id_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    a_d       = a_arr[grant_idx];
                    b_d       = b_arr[grant_idx];
                    mode_d    = req_mode[grant_idx];
                    id_d      = grant_idx;
                    // explicit wrap keeps non-power-of-two N_REQ correct
                    rr_ptr_d  = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                res_d    = dp_result;
                carry_d  = dp_carry;
                ovf_d    = dp_ovf;
                rsp_id_d = id_q;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            id_q     <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            id_q     <= id_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign rsp_id       = rsp_id_q;
    assign rsp_result   = res_q;
    assign rsp_carry    = carry_q;
    assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed vectors, corner sequences and
// randomized contention against an arithmetic/round-robin reference model.
module tb_addsub_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_mode;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry, rsp_overflow;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;
    int op_a [N];
    int op_b [N];
    int op_m [N];

    typedef struct {
        int id; int a; int b; int m;
        int r;  int c; int v;
    } vec_t;

    vec_t tv [6];
    int   fair_order [5];

    always #5 clk = ~clk;

    addsub_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_mode     (req_mode),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference arithmetic from plain integer math and signed range.
    function automatic void ref_op(input int a, input int b, input int m,
                                   output int r, output int c, output int v);
        int sa, sb, s, sv;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        if (m == 0) begin
            s  = a + b;
            r  = s % 16;
            c  = (s >= 16) ? 1 : 0;
            sv = sa + sb;
        end else begin
            s  = a - b;
            r  = (s + 16) % 16;
            c  = (a >= b) ? 1 : 0;
            sv = sa - sb;
        end
        v = (sv > 7 || sv < -8) ? 1 : 0;
    endfunction

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(op_a[i]);
            req_b[i*W +: W] = W'(op_b[i]);
            req_mode[i]     = op_m[i][0];
        end
    endtask

    // Starts and ends on a negedge with the DUT idle.
    task automatic transact(input logic [N-1:0] mask, input int hold, input bit poke,
                            output int got_id, output int got_r, output int got_c, output int got_v);
        int w, er, ec, ev;
        logic [W-1:0] first_r;
        logic [1:0]   first_id;
        got_id = -1; got_r = -1; got_c = -1; got_v = -1;
        load_ops();
        req_valid = mask;
        rsp_ready = (hold == 0);
        #1;
        w = pick(mask, model_ptr);
        if (w < 0) begin
            check("idle_no_grant", req_ready, 0);
            req_valid = '0;
            @(negedge clk);
            check("idle_quiet", rsp_valid, 0);
        end else begin
            check("grant", req_ready, 32'(1) << w);
            ref_op(op_a[w], op_b[w], op_m[w], er, ec, ev);
            @(posedge clk);
            #1 req_valid = '0;
            @(negedge clk);
            check("lat_calc_valid", rsp_valid, 0);
            check("calc_ready", req_ready, 0);
            @(negedge clk);
            check("lat_resp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, w);
            check("rsp_result", rsp_result, er);
            check("rsp_carry", rsp_carry, ec);
            check("rsp_overflow", rsp_overflow, ev);
            got_id = int'(rsp_id); got_r = int'(rsp_result);
            got_c = int'(rsp_carry); got_v = int'(rsp_overflow);
            first_r = rsp_result; first_id = rsp_id;
            for (int h = 0; h < hold; h++) begin
                if (poke) req_valid[2] = 1'b1;
                #1;
                check("bp_ready", req_ready, 0);
                check("bp_valid", rsp_valid, 1);
                check("bp_result_stable", rsp_result, first_r);
                check("bp_id_stable", rsp_id, first_id);
                @(negedge clk);
            end
            req_valid = '0;
            rsp_ready = 1'b1;
            @(posedge clk);
            model_ptr = (w + 1) % N;
            @(negedge clk);
            check("rsp_cleared", rsp_valid, 0);
            check("post_ready", req_ready, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  req_ready, 0);
        check({tag, "_valid"},  rsp_valid, 0);
        check({tag, "_id"},     rsp_id, 0);
        check({tag, "_result"}, rsp_result, 0);
        check({tag, "_carry"},  rsp_carry, 0);
        check({tag, "_ovf"},    rsp_overflow, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
    endtask

    initial begin
        int gid, gr, gc, gv;
        tv[0] = '{id: 0, a: 3,  b: 1, m: 0, r: 4,  c: 0, v: 0};
        tv[1] = '{id: 1, a: 15, b: 1, m: 0, r: 0,  c: 1, v: 0};
        tv[2] = '{id: 2, a: 7,  b: 5, m: 0, r: 12, c: 0, v: 1};
        tv[3] = '{id: 3, a: 1,  b: 3, m: 1, r: 14, c: 0, v: 0};
        tv[4] = '{id: 0, a: 8,  b: 9, m: 1, r: 15, c: 0, v: 0};
        tv[5] = '{id: 1, a: 9,  b: 3, m: 1, r: 6,  c: 1, v: 1};
        fair_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_mode = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin op_a[i] = 0; op_b[i] = 0; op_m[i] = 0; end
        do_reset();

        for (int i = 0; i < 6; i++) begin
            op_a[tv[i].id] = tv[i].a;
            op_b[tv[i].id] = tv[i].b;
            op_m[tv[i].id] = tv[i].m;
            transact(4'(1 << tv[i].id), 0, 1'b0, gid, gr, gc, gv);
            check("vec_id", gid, tv[i].id);
            check("vec_result", gr, tv[i].r);
            check("vec_carry", gc, tv[i].c);
            check("vec_ovf", gv, tv[i].v);
        end

        // back-pressure for 5 cycles while requester 2 raises and withdraws
        op_a[0] = 5; op_b[0] = 6; op_m[0] = 0;
        transact(4'b0001, 5, 1'b1, gid, gr, gc, gv);
        repeat (2) begin
            @(negedge clk);
            check("withdraw_no_grant", req_ready, 0);
            check("withdraw_no_rsp", rsp_valid, 0);
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < N; j++) begin
                op_a[j] = $urandom_range(0, 15); op_b[j] = $urandom_range(0, 15);
                op_m[j] = $urandom_range(0, 1);
            end
            transact(4'hF, 0, 1'b0, gid, gr, gc, gv);
            check("fair_order", gid, fair_order[i]);
        end

        // reset while in CALC with requester 1 in flight
        op_a[1] = 4; op_b[1] = 2; op_m[1] = 0;
        load_ops();
        req_valid = 4'b0010;
        #1 check("midrst_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_stale", rsp_valid, 0);
        end
        op_a[1] = 2; op_b[1] = 2; op_a[3] = 1; op_b[3] = 1;
        transact(4'b1010, 0, 1'b0, gid, gr, gc, gv);
        check("midrst_first_grant", gid, 1);

        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < N; j++) begin
                op_a[j] = $urandom_range(0, 15); op_b[j] = $urandom_range(0, 15);
                op_m[j] = $urandom_range(0, 1);
            end
            transact(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0, gid, gr, gc, gv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one 4-bit adder/subtractor datapath between up to N requesters. Each requester offers an operation (A, B, MODE) over a valid/ready handshake. The block grants one requester at a time, registers the operands, and computes through a single adder_subtractor instance. It returns RESULT/CARRY/OVERFLOW with the requester ID over a response valid/ready handshake. It sits between the requesting controllers and the shared arithmetic unit; only one operation is in flight at a time.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 4: operand width; must match the shared datapath.
- ID_W, default 2: width of rsp_id, equal to clog2(N_REQ).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- req_mode  in  N_REQ  0 = A+B, 1 = A-B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  WIDTH  sum/difference modulo 2^WIDTH.
- rsp_carry  out  1  carry-out; in subtract mode, 1 = no borrow.
- rsp_overflow  out  1  two's-complement signed overflow.

## Operation
- FSM states are IDLE, CALC and RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is set, select the winner by round-robin starting at rr_ptr.
  - Drive req_ready[winner]=1 combinationally in the same cycle; all other bits stay 0.
  - On the edge, capture a, b, mode and id into operand registers, then go to CALC.
  - If no req_valid is set, req_ready=0 and the block stays in IDLE.
- CALC:
  - The datapath computes from the captured registers.
  - On the edge, register result, carry, overflow and id into the response registers, then go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; the response registers hold stable.
  - On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
  - Back-pressure may last any number of cycles; req_ready=0 throughout.
- rr_ptr updates to (winner+1) mod N_REQ on each accept. Reset value is 0.
- Arithmetic:
  - Subtraction is A + ~B + 1.
  - overflow = (A[msb] == B'[msb]) & (R[msb] != A[msb]), where B' is the effective B.
- Requesters must hold req_a/req_b/req_mode stable while req_valid=1 and not accepted. Dropping req_valid before acceptance withdraws the request with no side effects.
- Simultaneous requests: exactly one is granted per IDLE cycle. A waiting requester is served within N_REQ grants.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_overflow=0, rr_ptr=0, state IDLE.
- Latency: accept at edge k; rsp_valid rises after edge k+1 and is visible in cycle k+2.
- Throughput: with rsp_ready held at 1, one operation every 3 cycles. The next grant can occur in the cycle after the response handshake.
- No combinational path from rsp_ready to req_ready. req_ready depends only on state, rr_ptr and req_valid.
- rst_n asserted mid-operation aborts the in-flight operation; no response is issued. After release, the block starts in IDLE with rr_ptr=0.

## Structure
- Shared package addsub_pkg holds:
  - the state enum (IDLE, CALC, RESP) and its encoding;
  - the MODE_ADD=0 and MODE_SUB=1 constants;
  - default WIDTH.
- Sub-module rr_arbiter (parameter N_REQ):
  - inputs: req vector, ptr;
  - outputs: one-hot grant and binary index;
  - purely combinational; reused by other shared-resource controllers.
- The datapath is one instance of the existing adder_subtractor, fed from the operand registers.

## Test plan
- Single add: requester 0, A=0011, B=0001, MODE=0 → accepted in 1 cycle; 2 cycles later rsp_id=0, result=0100, carry=0, overflow=0.
- Wrap and overflow:
  - 15+1 → result=0000, carry=1, overflow=0.
  - 7+5 → result=1100, carry=0, overflow=1.
  - 1-3 → result=1110, carry=0, overflow=0.
  - 8-9 → result=1111, carry=0, overflow=0.
  - 9-3 → result=0110, carry=1, overflow=1.
- Fairness: all 4 requesters valid continuously → responses ordered by id 0,1,2,3,0. No requester is granted twice before the others are served.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req_ready=0 throughout. Release → handshake, IDLE on the next cycle.
- Reset mid-op: assert rst_n=0 in CALC → all outputs 0 immediately. After release, no stale response appears and the first grant goes to the lowest valid requester from pointer 0.
- Withdrawal: requester 2 raises req_valid while the block is in RESP, then drops it before IDLE → no grant for requester 2 and no response.
